// File: rtl/mem_access_unit.sv
// Data-side load/store engine: formats stores into byte strobes plus
// aligned write data, issues memory requests over a valid/ready port and
// formats returned read data for register write-back.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  st_pick,
  input  logic [6:0]  ld_pick,
  input  logic [31:0] addr,
  input  logic [31:0] rt_val,
  input  logic [4:0]  dest,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  output logic        done_valid,
  input  logic        done_ready,
  output logic        wb_en,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Byte strobes for a resolved one-hot store pick {swr,swl,sb,sh,sw}.
  function automatic logic [3:0] store_wen(input logic [4:0] sel, input logic [1:0] o);
    logic [1:0] inv_o;
    inv_o = 2'd3 - o;
    case (sel)
      5'b00001: store_wen = 4'b1111;
      5'b00010: store_wen = o[1] ? 4'b1100 : 4'b0011;
      5'b00100: store_wen = 4'b0001 << o;
      5'b01000: store_wen = 4'b1111 >> inv_o;
      5'b10000: store_wen = 4'b1111 << o;
      default:  store_wen = 4'b0000;
    endcase
  endfunction

  // Lane-aligned write data for a resolved one-hot store pick.
  function automatic logic [31:0] store_data(input logic [4:0] sel, input logic [1:0] o,
                                             input logic [31:0] rt);
    logic [1:0] inv_o;
    inv_o = 2'd3 - o;
    case (sel)
      5'b00001: store_data = rt;
      5'b00010: store_data = {2{rt[15:0]}};
      5'b00100: store_data = {4{rt[7:0]}};
      5'b01000: store_data = rt >> {inv_o, 3'b000};
      5'b10000: store_data = rt << {o, 3'b000};
      default:  store_data = 32'h0000_0000;
    endcase
  endfunction

  // Extract/extend/merge a returned word for a resolved one-hot load pick.
  function automatic logic [31:0] load_fmt(input logic [6:0] sel, input logic [1:0] o,
                                           input logic [31:0] m, input logic [31:0] rt);
    logic [31:0] sh_m;
    logic [15:0] half;
    logic [31:0] res;
    sh_m = m >> {o, 3'b000};
    half = o[1] ? m[31:16] : m[15:0];
    case (sel)
      7'b0000001: res = {{24{sh_m[7]}}, sh_m[7:0]};
      7'b0000010: res = {24'h00_0000, sh_m[7:0]};
      7'b0000100: res = {{16{half[15]}}, half};
      7'b0001000: res = {16'h0000, half};
      7'b0010000: begin
        case (o)
          2'd0:    res = {m[7:0], rt[23:0]};
          2'd1:    res = {m[15:0], rt[15:0]};
          2'd2:    res = {m[23:0], rt[7:0]};
          default: res = m;
        endcase
      end
      7'b0100000: begin
        case (o)
          2'd0:    res = m;
          2'd1:    res = {rt[31:24], m[31:8]};
          2'd2:    res = {rt[31:16], m[31:16]};
          default: res = {rt[31:8], m[31:24]};
        endcase
      end
      7'b1000000: res = m;
      default:    res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  state_t      state_r, state_nx_s;
  logic [4:0]  st_low_s;
  logic [6:0]  ld_low_s;
  logic        is_st_s, is_ld_s, mis_st_s, mis_ld_s, go_mem_s, accept_s, tmo_s;
  logic        st_op_r;
  logic [6:0]  ld_sel_r;
  logic [1:0]  off_r;
  logic [31:0] rt_r;
  logic [31:0] cnt_r;
  logic        req_ready_r, mem_req_valid_r, done_valid_r, wb_en_r;
  logic [31:0] mem_addr_r, mem_wdata_r, wb_data_r;
  logic [3:0]  mem_wen_r;
  logic [4:0]  wb_dest_r;
  logic [1:0]  err_r;

  // Lowest set bit wins; a store pick masks any load pick.
  assign st_low_s = st_pick & (~st_pick + 5'd1);
  assign ld_low_s = ld_pick & (~ld_pick + 7'd1);
  assign is_st_s  = |st_pick;
  assign is_ld_s  = ~is_st_s & (|ld_pick);
  assign mis_st_s = is_st_s & ((st_low_s[0] & (|addr[1:0])) | (st_low_s[1] & addr[0]));
  assign mis_ld_s = is_ld_s & ((ld_low_s[6] & (|addr[1:0])) |
                               ((ld_low_s[2] | ld_low_s[3]) & addr[0]));
  assign go_mem_s = (is_st_s & ~mis_st_s) | (is_ld_s & ~mis_ld_s);
  assign accept_s = req_valid & req_ready_r;
  assign tmo_s    = (TIMEOUT != 32'd0) && (cnt_r == 32'(TIMEOUT - 32'd1));

  // Next-state logic; handshakes take priority over a coincident timeout.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nx_s = go_mem_s ? S_REQ : S_DONE;
        else          state_nx_s = S_IDLE;
      end
      S_REQ: begin
        if (mem_req_ready) state_nx_s = st_op_r ? S_DONE : S_WAIT;
        else if (tmo_s)    state_nx_s = S_DONE;
        else               state_nx_s = S_REQ;
      end
      S_WAIT: begin
        if (mem_rdata_valid) state_nx_s = S_DONE;
        else if (tmo_s)      state_nx_s = S_DONE;
        else                 state_nx_s = S_WAIT;
      end
      S_DONE: begin
        if (done_ready) state_nx_s = S_IDLE;
        else            state_nx_s = S_DONE;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= S_IDLE;
    else         state_r <= state_nx_s;
  end

  // Wait-cycle counter, restarted on every state change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                   cnt_r <= 32'd0;
    else if (state_nx_s != state_r)                cnt_r <= 32'd0;
    else if (state_r == S_REQ || state_r == S_WAIT) cnt_r <= cnt_r + 32'd1;
    else                                           cnt_r <= 32'd0;
  end

  // Request fields needed after accept to format the load result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_op_r  <= 1'b0;
      ld_sel_r <= 7'd0;
      off_r    <= 2'd0;
      rt_r     <= 32'd0;
    end else if (accept_s) begin
      st_op_r  <= is_st_s;
      ld_sel_r <= is_ld_s ? ld_low_s : 7'd0;
      off_r    <= addr[1:0];
      rt_r     <= rt_val;
    end
  end

  // Registered outputs: handshake flags follow the next state, fields
  // are loaded at accept and updated only on completion events.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_ready_r     <= 1'b1;
      mem_req_valid_r <= 1'b0;
      done_valid_r    <= 1'b0;
      mem_addr_r      <= 32'd0;
      mem_wen_r       <= 4'd0;
      mem_wdata_r     <= 32'd0;
      wb_en_r         <= 1'b0;
      wb_dest_r       <= 5'd0;
      wb_data_r       <= 32'd0;
      err_r           <= 2'b00;
    end else begin
      req_ready_r     <= (state_nx_s == S_IDLE);
      mem_req_valid_r <= (state_nx_s == S_REQ);
      done_valid_r    <= (state_nx_s == S_DONE);
      if (state_r == S_IDLE && accept_s) begin
        mem_addr_r  <= go_mem_s ? {addr[31:2], 2'b00} : 32'd0;
        mem_wen_r   <= (is_st_s & ~mis_st_s) ? store_wen(st_low_s, addr[1:0]) : 4'b0000;
        mem_wdata_r <= (is_st_s & ~mis_st_s) ? store_data(st_low_s, addr[1:0], rt_val) : 32'd0;
        wb_en_r     <= 1'b0;
        wb_dest_r   <= dest;
        wb_data_r   <= 32'd0;
        err_r       <= mis_st_s ? 2'b10 : (mis_ld_s ? 2'b01 : 2'b00);
      end else if (state_r == S_REQ && !mem_req_ready && tmo_s) begin
        err_r <= 2'b11;
      end else if (state_r == S_WAIT && mem_rdata_valid) begin
        wb_en_r   <= 1'b1;
        wb_data_r <= load_fmt(ld_sel_r, off_r, mem_rdata, rt_r);
      end else if (state_r == S_WAIT && tmo_s) begin
        err_r <= 2'b11;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign req_ready     = req_ready_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wen       = mem_wen_r;
  assign mem_wdata     = mem_wdata_r;
  assign done_valid    = done_valid_r;
  assign wb_en         = wb_en_r;
  assign wb_dest       = wb_dest_r;
  assign wb_data       = wb_data_r;
  assign err_code      = err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, timeout/reset sequences and
// random accesses checked against a byte-lane reference model.
module tb_mem_access_unit;

  logic        clk, resetn;
  logic        req_valid, req_ready;
  logic [4:0]  st_pick;
  logic [6:0]  ld_pick;
  logic [31:0] addr, rt_val;
  logic [4:0]  dest;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wen;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        done_valid, done_ready, wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [1:0]  err_code;

  int n_pass = 0;
  int n_total = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .st_pick(st_pick), .ld_pick(ld_pick), .addr(addr), .rt_val(rt_val), .dest(dest),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata(mem_rdata), .done_valid(done_valid), .done_ready(done_ready),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          go;
    bit          is_ld;
    logic [31:0] maddr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [4:0]  st;
    logic [6:0]  ld;
    logic [31:0] a;
    logic [31:0] rt;
    logic [31:0] m;
    logic [4:0]  d;
    int          rdly;
    int          ddly;
    int          kdly;
    bit          early;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: per byte lane, which source byte lands where.
  function automatic exp_t model(input logic [4:0] st, input logic [6:0] ld,
                                 input logic [31:0] a, input logic [31:0] rt,
                                 input logic [31:0] m, input int rdly, input int ddly);
    exp_t e;
    int ops, opl, o, sz, k;
    logic [7:0] mb[4];
    logic [7:0] rb[4];
    logic [7:0] v;
    logic [15:0] h;
    bit wr;
    e.go = 0; e.is_ld = 0; e.maddr = {a[31:2], 2'b00}; e.wen = 4'h0; e.wdata = 32'h0;
    e.wb_en = 1'b0; e.wb_data = 32'h0; e.err = 2'b00; e.lat = 1;
    ops = -1; opl = -1;
    for (int i = 0; i < 5; i++) if (st[i] && ops < 0) ops = i;
    if (ops < 0) for (int i = 0; i < 7; i++) if (ld[i] && opl < 0) opl = i;
    o = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      mb[i] = m[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    if (ops >= 0) begin
      sz = (ops == 0) ? 4 : (ops == 1) ? 2 : 1;
      if (o % sz != 0) e.err = 2'b10;
      else begin
        e.go = 1; e.lat = 2 + rdly;
        for (int i = 0; i < 4; i++) begin
          case (ops)
            0:       begin wr = 1;              k = i;         end
            1:       begin wr = (i/2 == o/2);   k = i % 2;     end
            2:       begin wr = (i == o);       k = 0;         end
            3:       begin wr = (i <= o);       k = i + 3 - o; end
            default: begin wr = (i >= o);       k = i - o;     end
          endcase
          e.wen[i] = wr;
          e.wdata[8*i +: 8] = (k >= 0 && k <= 3) ? rb[k] : 8'h00;
        end
      end
    end else if (opl >= 0) begin
      sz = (opl == 6) ? 4 : (opl == 2 || opl == 3) ? 2 : 1;
      if (o % sz != 0) e.err = 2'b01;
      else begin
        e.go = 1; e.is_ld = 1; e.wb_en = 1'b1; e.lat = 3 + rdly + ddly;
        v = mb[o];
        h = {mb[(o/2)*2 + 1], mb[(o/2)*2]};
        case (opl)
          0: e.wb_data = {{24{v[7]}}, v};
          1: e.wb_data = {24'h0, v};
          2: e.wb_data = {{16{h[15]}}, h};
          3: e.wb_data = {16'h0, h};
          4: for (int j = 0; j < 4; j++) e.wb_data[8*j +: 8] = (j >= 3 - o) ? mb[j - (3 - o)] : rb[j];
          5: for (int j = 0; j < 4; j++) e.wb_data[8*j +: 8] = (j <= 3 - o) ? mb[j + o] : rb[j];
          default: e.wb_data = {mb[3], mb[2], mb[1], mb[0]};
        endcase
      end
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [4:0] st, input logic [6:0] ld, input logic [31:0] a,
                              input logic [31:0] rt, input logic [31:0] m, input int rdly,
                              input int ddly, input int kdly, input bit early, input bit go,
                              input bit is_ld, input logic [3:0] wen, input logic [31:0] wdata,
                              input logic wbe, input logic [31:0] wbd, input logic [1:0] err,
                              input int lat);
    vec_t v;
    v.st = st; v.ld = ld; v.a = a; v.rt = rt; v.m = m; v.d = 5'(a[6:2] ^ 5'h15);
    v.rdly = rdly; v.ddly = ddly; v.kdly = kdly; v.early = early;
    v.e.go = go; v.e.is_ld = is_ld; v.e.maddr = {a[31:2], 2'b00}; v.e.wen = wen;
    v.e.wdata = wdata; v.e.wb_en = wbe; v.e.wb_data = wbd; v.e.err = err; v.e.lat = lat;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int cyc, bad, early;
    exp_t e;
    e = v.e;
    @(posedge clk); #1;
    req_valid = 1'b1; st_pick = v.st; ld_pick = v.ld; addr = v.a; rt_val = v.rt; dest = v.d;
    @(posedge clk); #1;
    req_valid = 1'b0; st_pick = 5'($urandom); ld_pick = 7'($urandom);
    addr = $urandom; rt_val = $urandom; dest = 5'($urandom);
    cyc = 1; bad = 0; early = 0;
    if (e.go) begin
      for (int k = 0; k <= v.rdly; k++) begin
        mem_req_ready   = (k == v.rdly);
        mem_rdata_valid = (k == v.rdly) && v.early;
        mem_rdata       = ~v.m;
        @(negedge clk);
        if (mem_req_valid !== 1'b1 || mem_addr !== e.maddr || mem_wen !== e.wen ||
            (!e.is_ld && mem_wdata !== e.wdata)) bad++;
        if (done_valid !== 1'b0 || req_ready !== 1'b0) early++;
        @(posedge clk); #1; cyc++;
      end
      mem_req_ready = 1'b0; mem_rdata_valid = 1'b0;
      chk("mem_req_fields", bad, 0);
      if (e.is_ld) begin
        for (int k = 0; k <= v.ddly; k++) begin
          mem_rdata_valid = (k == v.ddly);
          mem_rdata       = (k == v.ddly) ? v.m : $urandom;
          @(negedge clk);
          if (mem_req_valid !== 1'b0 || done_valid !== 1'b0) early++;
          @(posedge clk); #1; cyc++;
        end
        mem_rdata_valid = 1'b0;
      end
    end
    chk("early_done", early, 0);
    @(negedge clk);
    chk("done_lat", (done_valid === 1'b1) ? cyc : -1, e.lat);
    chk("mem_idle_at_done", mem_req_valid, 1'b0);
    chk("wb_en", wb_en, e.wb_en);
    chk("err_code", err_code, e.err);
    chk("wb_dest", wb_dest, v.d);
    if (e.wb_en) chk("wb_data", wb_data, e.wb_data);
    bad = 0;
    for (int k = 0; k <= v.kdly; k++) begin
      if (done_valid !== 1'b1 || req_ready !== 1'b0 || wb_en !== e.wb_en ||
          err_code !== e.err || wb_dest !== v.d || (e.wb_en && wb_data !== e.wb_data)) bad++;
      done_ready = (k == v.kdly);
      @(posedge clk); #1;
      if (k < v.kdly) @(negedge clk);
    end
    done_ready = 1'b0;
    chk("done_hold", bad, 0);
    @(negedge clk);
    chk("back_idle", {req_ready, done_valid}, 2'b10);
  endtask

  task automatic wait_done(input int cyc0, output int at);
    at = -1;
    for (int k = cyc0; k < cyc0 + 40; k++) begin
      @(negedge clk);
      if (done_valid === 1'b1) begin
        at = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic start_req(input logic [4:0] st, input logic [6:0] ld, input logic [31:0] a);
    @(posedge clk); #1;
    req_valid = 1'b1; st_pick = st; ld_pick = ld; addr = a; rt_val = 32'h1234_5678; dest = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    int at, bad, r;
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int at, bad, r;
    resetn = 1'b0; req_valid = 1'b0; st_pick = 5'd0; ld_pick = 7'd0; addr = 32'd0;
    rt_val = 32'd0; dest = 5'd0; mem_req_ready = 1'b0; mem_rdata_valid = 1'b0;
    mem_rdata = 32'd0; done_ready = 1'b0;
    #12;
    chk("reset_ctrl", {req_ready, mem_req_valid, done_valid, wb_en, err_code, wb_dest}, {1'b1, 10'd0});
    chk("reset_data", {mem_addr, mem_wdata}, 64'd0);
    chk("reset_wb", {mem_wen, wb_data}, 36'd0);
    @(negedge clk); resetn = 1'b1;

    tbl[0]  = mk(5'b00100, 7'd0, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0, 0, 0,
                 1, 0, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0, 2'b00, 2);
    tbl[1]  = mk(5'd0, 7'b0000001, 32'h2001, 32'h0, 32'h1234_80FF, 0, 0, 0, 0,
                 1, 1, 4'b0000, 32'h0, 1'b1, 32'hFFFF_FF80, 2'b00, 3);
    tbl[2]  = mk(5'd0, 7'b0000010, 32'h2001, 32'h0, 32'h1234_80FF, 0, 0, 1, 0,
                 1, 1, 4'b0000, 32'h0, 1'b1, 32'h0000_0080, 2'b00, 3);
    tbl[3]  = mk(5'd0, 7'b0010000, 32'h3001, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 0, 0,
                 1, 1, 4'b0000, 32'h0, 1'b1, 32'h3344_CCDD, 2'b00, 3);
    tbl[4]  = mk(5'd0, 7'b0100000, 32'h3001, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 0, 0,
                 1, 1, 4'b0000, 32'h0, 1'b1, 32'hAA11_2233, 2'b00, 3);
    tbl[5]  = mk(5'd0, 7'b1000000, 32'h4002, 32'h0, 32'h0, 0, 0, 0, 0,
                 0, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 2'b01, 1);
    tbl[6]  = mk(5'b00010, 7'd0, 32'h4001, 32'h0, 32'h0, 0, 0, 0, 0,
                 0, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 2'b10, 1);
    tbl[7]  = mk(5'b00001, 7'd0, 32'h5004, 32'hDEAD_BEEF, 32'h0, 3, 0, 2, 0,
                 1, 0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0, 2'b00, 5);
    tbl[8]  = mk(5'd0, 7'd0, 32'h5555, 32'h0, 32'h0, 0, 0, 0, 0,
                 0, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 2'b00, 1);
    tbl[9]  = mk(5'b00100, 7'b1000000, 32'h6002, 32'h0000_0012, 32'h0, 0, 0, 0, 0,
                 1, 0, 4'b0100, 32'h1212_1212, 1'b0, 32'h0, 2'b00, 2);
    tbl[10] = mk(5'b10110, 7'd0, 32'h7002, 32'h0000_BEEF, 32'h0, 1, 0, 0, 0,
                 1, 0, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0, 2'b00, 3);
    tbl[11] = mk(5'd0, 7'b0000100, 32'h8002, 32'h0, 32'h8001_1234, 0, 2, 0, 1,
                 1, 1, 4'b0000, 32'h0, 1'b1, 32'hFFFF_8001, 2'b00, 5);
    for (int i = 0; i < 12; i++) run_txn(tbl[i]);

    // Load whose data never returns: four WAIT cycles, then bus error.
    start_req(5'd0, 7'b1000000, 32'h9000);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    wait_done(2, at);
    chk("tmo_wait_lat", at, 6);
    chk("tmo_wait_fields", {err_code, wb_en, mem_req_valid}, {2'b11, 1'b0, 1'b0});
    done_ready = 1'b1; @(posedge clk); #1; done_ready = 1'b0;

    // Store never accepted: request dropped after four REQ cycles.
    start_req(5'b00001, 7'd0, 32'h9100);
    wait_done(1, at);
    chk("tmo_req_lat", at, 5);
    chk("tmo_req_fields", {err_code, wb_en, mem_req_valid}, {2'b11, 1'b0, 1'b0});
    done_ready = 1'b1; @(posedge clk); #1; done_ready = 1'b0;

    // Reset asserted while waiting for read data.
    start_req(5'd0, 7'b1000000, 32'hA000);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    #2 resetn = 1'b0;
    #1 chk("rst_mid", {req_ready, mem_req_valid, done_valid}, 3'b100);
    @(negedge clk); resetn = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mem_rdata_valid = (k == 0); mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      if (done_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    mem_rdata_valid = 1'b0;
    chk("rst_no_done", bad, 0);

    // Random accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      rv.st = (r < 4) ? 5'(1 << $urandom_range(0, 4)) : (r == 4) ? 5'($urandom) : 5'd0;
      r = $urandom_range(0, 9);
      rv.ld = (r < 7) ? 7'(1 << $urandom_range(0, 6)) : (r == 7) ? 7'($urandom) : 7'd0;
      rv.a = $urandom; rv.rt = $urandom; rv.m = $urandom; rv.d = 5'($urandom);
      rv.rdly = $urandom_range(0, 2); rv.ddly = $urandom_range(0, 2);
      rv.kdly = $urandom_range(0, 2); rv.early = 1'($urandom);
      rv.e = model(rv.st, rv.ld, rv.a, rv.rt, rv.m, rv.rdly, rv.ddly);
      run_txn(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
